// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target
// Brief    : I2C target exposing a 4 x 8-bit register file to an external
//            master, with a local read/write port onto the same registers.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target #(
    parameter logic [6:0] TGT_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [1:0] loc_addr,
    input  logic       loc_wr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic       i2c_wr_pulse,
    output logic       busy
);

    typedef enum logic [3:0] {
        c_st_idle      = 4'd0,
        c_st_addr      = 4'd1,
        c_st_ack_addr  = 4'd2,
        c_st_wr_ptr    = 4'd3,
        c_st_wr_data   = 4'd4,
        c_st_wr_ack    = 4'd5,
        c_st_rd_byte   = 4'd6,
        c_st_rd_ack    = 4'd7,
        c_st_idle_wait = 4'd8
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    state_t      r_state, w_state_nx;
    logic [2:0]  r_cnt, w_cnt_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        r_done, w_done_nx;
    logic        r_rw, w_rw_nx;
    logic        r_mack, w_mack_nx;
    logic        r_sda_oe, w_sda_oe_nx;
    logic        r_busy, w_busy_nx;
    logic [1:0]  r_ptr, w_ptr_nx;
    logic [7:0]  r_regs [4];

    logic        w_scl, w_sda;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_byte;
    logic        w_i2c_we;
    logic [1:0]  w_i2c_waddr;
    logic [7:0]  w_i2c_wdata;

    // Idle-high reset values keep the first synchronized samples from faking a START/STOP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= c_st_idle;
            r_cnt    <= 3'd0;
            r_shift  <= 8'd0;
            r_done   <= 1'b0;
            r_rw     <= 1'b0;
            r_mack   <= 1'b1;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_ptr    <= 2'd0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_shift  <= w_shift_nx;
            r_done   <= w_done_nx;
            r_rw     <= w_rw_nx;
            r_mack   <= w_mack_nx;
            r_sda_oe <= w_sda_oe_nx;
            r_busy   <= w_busy_nx;
            r_ptr    <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_shift_nx  = r_shift;
        w_done_nx   = r_done;
        w_rw_nx     = r_rw;
        w_mack_nx   = r_mack;
        w_sda_oe_nx = r_sda_oe;
        w_busy_nx   = r_busy;
        w_ptr_nx    = r_ptr;
        w_i2c_we    = 1'b0;
        w_i2c_waddr = r_ptr;
        w_i2c_wdata = w_byte;

        if (w_start) begin
            w_state_nx  = c_st_addr;
            w_cnt_nx    = 3'd0;
            w_done_nx   = 1'b0;
            w_sda_oe_nx = 1'b0;
        end else if (w_stop) begin
            w_state_nx  = c_st_idle;
            w_done_nx   = 1'b0;
            w_sda_oe_nx = 1'b0;
            w_busy_nx   = 1'b0;
        end else begin
            case (r_state)
                c_st_addr: begin
                    if (w_scl_rise) begin
                        w_shift_nx = w_byte;
                        w_cnt_nx   = r_cnt + 3'd1;
                        w_done_nx  = (r_cnt == 3'd7);
                    end else if (w_scl_fall && r_done) begin
                        w_done_nx = 1'b0;
                        if (r_shift[7:1] == TGT_ADDR) begin
                            w_sda_oe_nx = 1'b1;
                            w_busy_nx   = 1'b1;
                            w_rw_nx     = r_shift[0];
                            w_state_nx  = c_st_ack_addr;
                        end else begin
                            w_sda_oe_nx = 1'b0;
                            w_busy_nx   = 1'b0;
                            w_state_nx  = c_st_idle;
                        end
                    end
                end
                c_st_ack_addr: begin
                    if (w_scl_fall) begin
                        w_cnt_nx = 3'd0;
                        if (r_rw) begin
                            w_shift_nx  = r_regs[r_ptr];
                            w_sda_oe_nx = ~r_regs[r_ptr][7];
                            w_ptr_nx    = r_ptr + 2'd1;
                            w_state_nx  = c_st_rd_byte;
                        end else begin
                            w_sda_oe_nx = 1'b0;
                            w_state_nx  = c_st_wr_ptr;
                        end
                    end
                end
                c_st_wr_ptr, c_st_wr_data: begin
                    if (w_scl_rise) begin
                        w_shift_nx = w_byte;
                        w_cnt_nx   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_done_nx = 1'b1;
                            if (r_state == c_st_wr_ptr) begin
                                w_ptr_nx = w_byte[1:0];
                            end else begin
                                w_i2c_we = 1'b1;
                                w_ptr_nx = r_ptr + 2'd1;
                            end
                        end
                    end else if (w_scl_fall && r_done) begin
                        w_done_nx   = 1'b0;
                        w_sda_oe_nx = 1'b1;
                        w_state_nx  = c_st_wr_ack;
                    end
                end
                c_st_wr_ack: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nx = 1'b0;
                        w_cnt_nx    = 3'd0;
                        w_state_nx  = c_st_wr_data;
                    end
                end
                c_st_rd_byte: begin
                    if (w_scl_rise) begin
                        w_cnt_nx  = r_cnt + 3'd1;
                        w_done_nx = (r_cnt == 3'd7);
                    end else if (w_scl_fall) begin
                        if (r_done) begin
                            w_done_nx   = 1'b0;
                            w_sda_oe_nx = 1'b0;
                            w_state_nx  = c_st_rd_ack;
                        end else begin
                            w_shift_nx  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nx = ~r_shift[6];
                        end
                    end
                end
                c_st_rd_ack: begin
                    if (w_scl_rise) begin
                        w_mack_nx = w_sda;
                    end else if (w_scl_fall) begin
                        if (!r_mack) begin
                            w_shift_nx  = r_regs[r_ptr];
                            w_sda_oe_nx = ~r_regs[r_ptr][7];
                            w_ptr_nx    = r_ptr + 2'd1;
                            w_cnt_nx    = 3'd0;
                            w_state_nx  = c_st_rd_byte;
                        end else begin
                            w_sda_oe_nx = 1'b0;
                            w_state_nx  = c_st_idle_wait;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The local write is applied last so it wins a same-register collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'd0;
            end
        end else begin
            if (w_i2c_we) begin
                r_regs[w_i2c_waddr] <= w_i2c_wdata;
            end
            if (loc_wr) begin
                r_regs[loc_addr] <= loc_wdata;
            end
        end
    end

    assign sda_oe       = r_sda_oe;
    assign busy         = r_busy;
    assign i2c_wr_pulse = w_i2c_we;
    assign loc_rdata    = r_regs[loc_addr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target
// Brief    : Directed bench for i2c_target with a bit-banged I2C master.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_target;

    localparam time c_Q = 40;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [1:0] loc_addr = 2'd0;
    logic       loc_wr = 1'b0;
    logic [7:0] loc_wdata = 8'd0;
    logic       sda_oe;
    logic [7:0] loc_rdata;
    logic       i2c_wr_pulse;
    logic       busy;
    logic       sda_line;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target #(.TGT_ADDR(7'h42), .SYNC_STAGES(2)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .scl          (scl),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .loc_addr     (loc_addr),
        .loc_wr       (loc_wr),
        .loc_wdata    (loc_wdata),
        .loc_rdata    (loc_rdata),
        .i2c_wr_pulse (i2c_wr_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic mon_en = 1'b0;
    int   oe_seen = 0;
    int   busy_seen = 0;
    int   pulse_cnt = 0;

    always @(posedge clk) begin
        if (mon_en && sda_oe) oe_seen++;
        if (mon_en && busy)   busy_seen++;
        if (i2c_wr_pulse)     pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        loc_addr = a;
        #1;
        check(tag, {24'd0, loc_rdata}, {24'd0, exp});
    endtask

    task automatic loc_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_addr  = a;
        loc_wdata = d;
        loc_wr    = 1'b1;
        @(negedge clk);
        loc_wr    = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #c_Q;
        scl   = 1'b1; #c_Q;
        m_sda = 1'b0; #c_Q;
        scl   = 1'b0; #c_Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #c_Q;
        scl   = 1'b1; #c_Q;
        m_sda = 1'b1; #c_Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #c_Q;
            scl = 1'b1; #(2*c_Q);
            scl = 1'b0; #c_Q;
        end
        m_sda = 1'b1; #c_Q;
        scl = 1'b1; #c_Q;
        ack = sda_line; #c_Q;
        scl = 1'b0; #c_Q;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #c_Q; scl = 1'b1;
            #c_Q; b[i] = sda_line;
            #c_Q; scl = 1'b0;
            #c_Q;
        end
        m_sda = mack; #c_Q;
        scl = 1'b1; #(2*c_Q);
        scl = 1'b0; #c_Q;
        m_sda = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic       hit;
        logic [7:0] rb;
        int         p0, o0, b0;

        #23;
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulse", {31'd0, i2c_wr_pulse}, 32'd0);
        #29 rstn = 1'b1;
        #20;
        for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), 8'h00);

        // Plain write of two data bytes starting at register 1.
        p0 = pulse_cnt;
        bus_start();
        write_byte(8'h84, ack); check("wr_addr_ack", {31'd0, ack}, 32'd0);
        check("wr_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h01, ack); check("wr_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hAA, ack); check("wr_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'hBB, ack); check("wr_d1_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        #(4*c_Q);
        check("wr_busy_stop", {31'd0, busy}, 32'd0);
        check("wr_pulses", pulse_cnt - p0, 32'd2);
        chk_reg("wr_reg1", 2'd1, 8'hAA);
        chk_reg("wr_reg2", 2'd2, 8'hBB);
        chk_reg("wr_reg0", 2'd0, 8'h00);

        // Pointer wraps 3 -> 0.
        bus_start();
        write_byte(8'h84, ack); check("wrap_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h03, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); check("wrap_d1_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        #(4*c_Q);
        chk_reg("wrap_reg3", 2'd3, 8'h11);
        chk_reg("wrap_reg0", 2'd0, 8'h22);

        // Pointer left at 1: a bare read returns regs[1].
        bus_start();
        write_byte(8'h85, ack); check("ptr_rd_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b1, rb);    check("ptr_rd_data", {24'd0, rb}, 32'hAA);
        bus_stop();
        #(4*c_Q);

        // Read with repeated START.
        loc_write(2'd0, 8'h10);
        loc_write(2'd1, 8'h20);
        loc_write(2'd2, 8'h30);
        loc_write(2'd3, 8'h40);
        chk_reg("loc_reg2", 2'd2, 8'h30);
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h02, ack); check("rd_ptr_ack", {31'd0, ack}, 32'd0);
        bus_start();
        write_byte(8'h85, ack); check("rd_addr_ack", {31'd0, ack}, 32'd0);
        read_byte(1'b0, rb);    check("rd_byte0", {24'd0, rb}, 32'h30);
        read_byte(1'b1, rb);    check("rd_byte1", {24'd0, rb}, 32'h40);
        check("rd_busy", {31'd0, busy}, 32'd1);
        bus_stop();
        #(4*c_Q);
        check("rd_busy_stop", {31'd0, busy}, 32'd0);

        // Address mismatch: target stays silent.
        o0 = oe_seen; b0 = busy_seen; p0 = pulse_cnt;
        mon_en = 1'b1;
        bus_start();
        write_byte(8'h90, ack); check("mis_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h12, ack); check("mis_data_nack", {31'd0, ack}, 32'd1);
        bus_stop();
        #(4*c_Q);
        mon_en = 1'b0;
        check("mis_oe", oe_seen - o0, 32'd0);
        check("mis_busy", busy_seen - b0, 32'd0);
        check("mis_pulse", pulse_cnt - p0, 32'd0);
        chk_reg("mis_reg0", 2'd0, 8'h10);
        chk_reg("mis_reg2", 2'd2, 8'h30);

        // Local write collides with the I2C commit to regs[2].
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h02, ack);
        hit = 1'b0;
        fork
            write_byte(8'h55, ack);
            begin
                for (int k = 0; k < 400 && !hit; k++) begin
                    @(negedge clk);
                    if (i2c_wr_pulse) begin
                        loc_addr  = 2'd2;
                        loc_wdata = 8'h77;
                        loc_wr    = 1'b1;
                        hit       = 1'b1;
                        @(negedge clk);
                        loc_wr    = 1'b0;
                    end
                end
            end
        join
        check("col_hit", {31'd0, hit}, 32'd1);
        check("col_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        #(4*c_Q);
        chk_reg("col_reg2", 2'd2, 8'h77);
        chk_reg("col_reg3", 2'd3, 8'h40);

        // Reset while the target drives a 0 bit of regs[3] = 0x40.
        bus_start();
        write_byte(8'h85, ack); check("rst_rd_ack", {31'd0, ack}, 32'd0);
        check("rst_rd_drive", {31'd0, sda_oe}, 32'd1);
        #3 rstn = 1'b0;
        #1;
        check("rst_async_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        #c_Q rstn = 1'b1;
        o0 = oe_seen;
        mon_en = 1'b1;
        write_byte(8'h84, ack); check("rst_ign_nack0", {31'd0, ack}, 32'd1);
        write_byte(8'h00, ack); check("rst_ign_nack1", {31'd0, ack}, 32'd1);
        mon_en = 1'b0;
        check("rst_ign_oe", oe_seen - o0, 32'd0);
        bus_stop();
        #(4*c_Q);
        chk_reg("rst_reg3", 2'd3, 8'h00);

        p0 = pulse_cnt;
        bus_start();
        write_byte(8'h84, ack); check("post_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h00, ack); check("post_ptr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h5A, ack); check("post_d_ack", {31'd0, ack}, 32'd0);
        bus_stop();
        #(4*c_Q);
        chk_reg("post_reg0", 2'd0, 8'h5A);
        check("post_pulse", pulse_cnt - p0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
